// File: rtl/ssd_pkg.sv
// Shared seven-segment constants for the scan decoder and the stopwatch encoder.
// Segment patterns are active-low {a,b,c,d,e,f,g,dp} with dp off.
package ssd_pkg;

    localparam logic [7:0] SEG_0     = 8'h03;
    localparam logic [7:0] SEG_1     = 8'h9F;
    localparam logic [7:0] SEG_2     = 8'h25;
    localparam logic [7:0] SEG_3     = 8'h0D;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h49;
    localparam logic [7:0] SEG_6     = 8'h41;
    localparam logic [7:0] SEG_7     = 8'h1F;
    localparam logic [7:0] SEG_8     = 8'h01;
    localparam logic [7:0] SEG_9     = 8'h09;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [3:0] CODE_BLANK   = 4'hC;
    localparam logic [3:0] CODE_INVALID = 4'hF;

    localparam logic [3:0] DIG_SEL0 = 4'b1110;
    localparam logic [3:0] DIG_SEL1 = 4'b1101;
    localparam logic [3:0] DIG_SEL2 = 4'b1011;
    localparam logic [3:0] DIG_SEL3 = 4'b0111;

    typedef enum logic {
        ST_SETTLING = 1'b0,
        ST_HELD     = 1'b1
    } dwell_state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } dig_sel_t;

    // Only a single low anode is a real digit; idle and multi-low patterns are not.
    function automatic dig_sel_t dig_select(input logic [3:0] dig);
        dig_sel_t sel;
        sel.valid = 1'b1;
        sel.idx   = 2'd0;
        case (dig)
            DIG_SEL0: sel.idx = 2'd0;
            DIG_SEL1: sel.idx = 2'd1;
            DIG_SEL2: sel.idx = 2'd2;
            DIG_SEL3: sel.idx = 2'd3;
            default:  sel.valid = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/ssd_seg_to_bcd.sv
// Combinational seven-segment pattern to digit code decoder.
// Unknown patterns decode to CODE_INVALID, an all-dark digit to CODE_BLANK.
module ssd_seg_to_bcd
    import ssd_pkg::*;
(
    input  logic [7:0] seg_i,
    output logic [3:0] code_o
);

    always_comb begin
        code_o = CODE_INVALID;
        case (seg_i)
            SEG_0:     code_o = 4'd0;
            SEG_1:     code_o = 4'd1;
            SEG_2:     code_o = 4'd2;
            SEG_3:     code_o = 4'd3;
            SEG_4:     code_o = 4'd4;
            SEG_5:     code_o = 4'd5;
            SEG_6:     code_o = 4'd6;
            SEG_7:     code_o = 4'd7;
            SEG_8:     code_o = 4'd8;
            SEG_9:     code_o = 4'd9;
            SEG_BLANK: code_o = CODE_BLANK;
            default:   code_o = CODE_INVALID;
        endcase
    end

endmodule

// File: rtl/ssd_scan_decoder.sv
// Rebuilds four BCD digits from a scanned DIGIT/DISPLAY pair, with ghost filtering and link-loss detection.
// Optional macro SSD_SCAN_DP_DECODE_EN: ignore dp during decode and publish per-digit dp_flags.
module ssd_scan_decoder
    import ssd_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int FRAME_TIMEOUT = 4194304
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  DIGIT,
    input  logic [7:0]  DISPLAY,
    output logic [15:0] value,
    output logic        frame_valid,
    output logic        seg_error,
    output logic        link_lost
`ifdef SSD_SCAN_DP_DECODE_EN
    ,
    output logic [3:0]  dp_flags
`endif
);

    localparam logic [7:0]  CNT_SAT = 8'(STABLE_CYCLES);
    localparam logic [7:0]  CNT_CAP = 8'(STABLE_CYCLES - 1);
    localparam logic [22:0] TO_LAST = 23'(FRAME_TIMEOUT - 1);

    logic [3:0]       dig_q, dig_prev_q;
    logic [7:0]       seg_q, seg_prev_q;
    logic             changed;
    logic [7:0]       cnt_q, cnt_d;
    dwell_state_t     state_q, state_d;
    logic             capture;
    dig_sel_t         sel;
    logic [7:0]       seg_dec;
    logic [3:0]       code;
    logic [3:0]       seen_q, seen_d;
    logic [3:0][3:0]  shadow_q, shadow_d;
    logic             publish;
    logic             frame_err;
    logic [22:0]      to_q;
    logic [15:0]      value_q;
    logic             frame_valid_q;
    logic             seg_error_q;
    logic             link_lost_q;

    // Sample stage resets to the idle pattern so the first real digit reads as a change.
    always_ff @(posedge clk) begin
        if (reset) begin
            dig_q      <= 4'hF;
            seg_q      <= 8'hFF;
            dig_prev_q <= 4'hF;
            seg_prev_q <= 8'hFF;
        end else begin
            dig_q      <= DIGIT;
            seg_q      <= DISPLAY;
            dig_prev_q <= dig_q;
            seg_prev_q <= seg_q;
        end
    end

    assign changed = ({dig_q, seg_q} != {dig_prev_q, seg_prev_q});
    assign sel     = dig_select(dig_q);

    always_comb begin
        cnt_d = cnt_q;
        if (changed) begin
            cnt_d = 8'd0;
        end else if (cnt_q < CNT_SAT) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            ST_SETTLING: begin
                if (!changed && (cnt_d == CNT_CAP)) begin
                    state_d = ST_HELD;
                    capture = sel.valid;
                end
            end
            ST_HELD: begin
                if (changed) begin
                    state_d = ST_SETTLING;
                end
            end
            default: state_d = ST_SETTLING;
        endcase
    end

`ifdef SSD_SCAN_DP_DECODE_EN
    assign seg_dec = {seg_q[7:1], 1'b1};
`else
    assign seg_dec = seg_q;
`endif

    ssd_seg_to_bcd u_seg_to_bcd (
        .seg_i  (seg_dec),
        .code_o (code)
    );

    assign publish = (seen_q == 4'hF);

    always_comb begin
        seen_d    = publish ? 4'h0 : seen_q;
        shadow_d  = shadow_q;
        frame_err = 1'b0;
        if (capture) begin
            seen_d[sel.idx]   = 1'b1;
            shadow_d[sel.idx] = code;
        end
        for (int i = 0; i < 4; i++) begin
            if (shadow_q[i] == CODE_INVALID) begin
                frame_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= 8'd0;
            state_q  <= ST_SETTLING;
            seen_q   <= 4'h0;
            shadow_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            seen_q   <= seen_d;
            shadow_q <= shadow_d;
        end
    end

    // A publish on the timeout cycle wins: the counter clears and link_lost stays low.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_q       <= 16'h0000;
            frame_valid_q <= 1'b0;
            seg_error_q   <= 1'b0;
            link_lost_q   <= 1'b0;
            to_q          <= 23'd0;
        end else begin
            frame_valid_q <= publish;
            if (publish) begin
                value_q     <= shadow_q;
                seg_error_q <= frame_err;
                link_lost_q <= 1'b0;
                to_q        <= 23'd0;
            end else if (to_q == TO_LAST) begin
                link_lost_q <= 1'b1;
            end else begin
                to_q <= to_q + 23'd1;
            end
        end
    end

`ifdef SSD_SCAN_DP_DECODE_EN
    logic [3:0] dp_shadow_q;
    logic [3:0] dp_flags_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            dp_shadow_q <= 4'h0;
            dp_flags_q  <= 4'h0;
        end else begin
            if (capture) begin
                dp_shadow_q[sel.idx] <= ~seg_q[0];
            end
            if (publish) begin
                dp_flags_q <= dp_shadow_q;
            end
        end
    end

    assign dp_flags = dp_flags_q;
`endif

    assign value       = value_q;
    assign frame_valid = frame_valid_q;
    assign seg_error   = seg_error_q;
    assign link_lost   = link_lost_q;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Self-checking bench for ssd_scan_decoder: directed scans plus random dwells against a run-length reference model.
module tb_ssd_scan_decoder;

    localparam int S = 4;
    localparam int T = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  DIGIT = 4'hF;
    logic [7:0]  DISPLAY = 8'hFF;
    logic [15:0] value;
    logic        frame_valid;
    logic        seg_error;
    logic        link_lost;
`ifdef SSD_SCAN_DP_DECODE_EN
    logic [3:0]  dp_flags;
`endif

    always #5 clk = ~clk;

    ssd_scan_decoder #(.STABLE_CYCLES(S), .FRAME_TIMEOUT(T)) dut (
        .clk         (clk),
        .reset       (reset),
        .DIGIT       (DIGIT),
        .DISPLAY     (DISPLAY),
        .value       (value),
        .frame_valid (frame_valid),
        .seg_error   (seg_error),
        .link_lost   (link_lost)
`ifdef SSD_SCAN_DP_DECODE_EN
        ,
        .dp_flags    (dp_flags)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: a digit is captured when an input pair has been held S cycles in a row.
    logic [7:0] pat_tab [11] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49,
                                 8'h41, 8'h1F, 8'h01, 8'h09, 8'hFF};

    typedef struct {
        logic [15:0] val;
        logic        err;
        logic [3:0]  dp;
    } frame_t;

    frame_t     exp_q[$];
    logic [11:0] m_prev;
    int          m_len;
    logic [3:0]  m_code [4];
    logic        m_dp [4];
    logic [3:0]  m_seen;

    function automatic logic [3:0] ref_decode(input logic [7:0] disp);
        logic [7:0] p;
        p = disp;
`ifdef SSD_SCAN_DP_DECODE_EN
        p[0] = 1'b1;
`endif
        for (int k = 0; k < 11; k++) begin
            if (pat_tab[k] == p) return (k == 10) ? 4'hC : 4'(k);
        end
        return 4'hF;
    endfunction

    task automatic model_reset();
        m_prev = 12'hFFF;
        m_len  = 1;
        m_seen = 4'h0;
        for (int k = 0; k < 4; k++) begin
            m_code[k] = 4'h0;
            m_dp[k]   = 1'b0;
        end
    endtask

    task automatic model_step(input logic [3:0] dig, input logic [7:0] disp);
        logic [3:0] oh;
        frame_t     f;
        if ({dig, disp} == m_prev) m_len++;
        else begin
            m_len  = 1;
            m_prev = {dig, disp};
        end
        if (m_len == S) begin
            for (int k = 0; k < 4; k++) begin
                oh = 4'b0001 << k;
                if (dig == ~oh) begin
                    m_code[k] = ref_decode(disp);
                    m_dp[k]   = ~disp[0];
                    m_seen[k] = 1'b1;
                end
            end
            if (m_seen == 4'hF) begin
                f.val = {m_code[3], m_code[2], m_code[1], m_code[0]};
                f.err = 1'b0;
                for (int k = 0; k < 4; k++) if (m_code[k] == 4'hF) f.err = 1'b1;
                f.dp  = {m_dp[3], m_dp[2], m_dp[1], m_dp[0]};
                exp_q.push_back(f);
                m_seen = 4'h0;
            end
        end
    endtask

    task automatic drive(input logic [3:0] dig, input logic [7:0] disp, input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            DIGIT   = dig;
            DISPLAY = disp;
            model_step(dig, disp);
        end
    endtask

    // Scans digit0 first, 20 cycles per digit.
    task automatic scan4(input logic [7:0] d3, input logic [7:0] d2,
                         input logic [7:0] d1, input logic [7:0] d0);
        drive(4'b1110, d0, 20);
        drive(4'b1101, d1, 20);
        drive(4'b1011, d2, 20);
        drive(4'b0111, d3, 20);
        drive(4'b1111, 8'hFF, 5);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        reset   = 1'b1;
        DIGIT   = 4'hF;
        DISPLAY = 8'hFF;
        model_reset();
        repeat (n) @(posedge clk);
        @(negedge clk);
        chk("rst_value", value, 16'h0000);
        chk("rst_fv", frame_valid, 1'b0);
        chk("rst_segerr", seg_error, 1'b0);
        chk("rst_linklost", link_lost, 1'b0);
`ifdef SSD_SCAN_DP_DECODE_EN
        chk("rst_dp", dp_flags, 4'h0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    int          since = 0;
    logic        fv_prev = 1'b0;
    int          n_frames = 0;
    logic [15:0] last_val = 16'h0000;

    always @(negedge clk) begin
        frame_t f;
        if (reset) begin
            since   = -1;
            fv_prev = 1'b0;
        end else begin
            if (frame_valid) begin
                since = 0;
                n_frames++;
                chk("fv_pulse", fv_prev, 1'b0);
                chk("ll_on_fv", link_lost, 1'b0);
                if (exp_q.size() == 0) begin
                    chk("unexp_frame", frame_valid, 1'b0);
                end else begin
                    f = exp_q.pop_front();
                    chk("value", value, f.val);
                    chk("seg_err", seg_error, f.err);
`ifdef SSD_SCAN_DP_DECODE_EN
                    chk("dp_flags", dp_flags, f.dp);
`endif
                    last_val = f.val;
                end
            end else begin
                since++;
            end
            if (since == T - 1) chk("ll_before_timeout", link_lost, 1'b0);
            if (since == T)     chk("ll_at_timeout", link_lost, 1'b1);
            fv_prev = frame_valid;
        end
    end

    initial begin
        int f0;
        logic [3:0] dig;
        logic [7:0] disp;

        model_reset();
        do_reset(3);
        drive(4'b1111, 8'hFF, 5);

        scan4(8'h0D, 8'h25, 8'h9F, 8'h03);
        chk("tp1_value", value, 16'h3210);
        chk("tp1_segerr", seg_error, 1'b0);
        chk("tp1_frames", n_frames, 1);

        f0 = n_frames;
        drive(4'b1110, 8'h49, 1);
        drive(4'b1101, 8'h99, 3);
        drive(4'b1011, 8'h41, 3);
        drive(4'b1110, 8'h49, 1);
        drive(4'b0111, 8'h1F, 3);
        drive(4'b1110, 8'h01, 3);
        drive(4'b1111, 8'hFF, 8);
        chk("tp2_no_frame", n_frames - f0, 0);
        chk("tp2_value_hold", value, 16'h3210);

        scan4(8'h49, 8'h09, 8'hAA, 8'h9F);
        chk("tp3_value", value, 16'h59F1);
        chk("tp3_segerr", seg_error, 1'b1);
        scan4(8'h99, 8'h0D, 8'h25, 8'h9F);
        chk("tp3_clean_value", value, 16'h4321);
        chk("tp3_segerr_clear", seg_error, 1'b0);

        drive(4'b1111, 8'hFF, 300);
        chk("tp4_link_lost", link_lost, 1'b1);
        scan4(8'h41, 8'h1F, 8'h01, 8'h09);
        chk("tp4_value", value, 16'h6789);
        chk("tp4_link_back", link_lost, 1'b0);

        drive(4'b1110, 8'h49, 20);
        drive(4'b1101, 8'h49, 20);
        drive(4'b1011, 8'h49, 20);
        chk("tp5_q_empty", exp_q.size(), 0);
        do_reset(2);
        drive(4'b1111, 8'hFF, 5);
        f0 = n_frames;
        drive(4'b0111, 8'h1F, 20);
        drive(4'b1011, 8'h03, 20);
        drive(4'b1101, 8'h9F, 20);
        drive(4'b1110, 8'h25, 20);
        drive(4'b1111, 8'hFF, 5);
        chk("tp5_frames", n_frames - f0, 1);
        chk("tp5_value", value, 16'h7012);

        scan4(8'h9F, 8'h00, 8'h25, 8'h0D);
`ifdef SSD_SCAN_DP_DECODE_EN
        chk("tp6_value", value, 16'h1823);
        chk("tp6_dp", dp_flags, 4'b0100);
        chk("tp6_segerr", seg_error, 1'b0);
`else
        chk("tp6_value", value, 16'h1F23);
        chk("tp6_segerr", seg_error, 1'b1);
`endif

        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 7) == 0) dig = 4'($urandom_range(0, 15));
            else begin
                dig = 4'b0001 << $urandom_range(0, 3);
                dig = ~dig;
            end
            if ($urandom_range(0, 4) == 0) disp = 8'($urandom_range(0, 255));
            else begin
                disp = pat_tab[$urandom_range(0, 10)];
                if ($urandom_range(0, 5) == 0) disp[0] = 1'b0;
            end
            drive(dig, disp, $urandom_range(1, 8));
        end
        drive(4'b1111, 8'hFF, 20);
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_value_hold", value, last_val);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ssd_scan_decoder.md
Name: ssd_scan_decoder

Overview:
- Receive side of the 4-digit multiplexed seven-segment interface: consumes the scanned DIGIT/DISPLAY pair and rebuilds the four displayed BCD digits.
- Used as a readback monitor for on-board self-check and to drive the stopwatch display from a second board.
- Filters scan-transition ghosting and flags undecodable segment patterns.
- Detects loss of scanning activity.

Parameters:
- STABLE_CYCLES, 16: consecutive identical samples of {DIGIT,DISPLAY} required before a digit is captured; legal range 2..255.
- FRAME_TIMEOUT, 4194304: cycles without a completed frame before link_lost asserts.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- DIGIT  in  4  anode select, active-low one-hot; 4'b1110 = digit0 (rightmost), 4'b0111 = digit3.
- DISPLAY  in  8  segments, active-low, bit order {a,b,c,d,e,f,g,dp}, MSB = a.
- value  out  16  {digit3,digit2,digit1,digit0}, 4-bit codes: 0-9 BCD, 4'hC blank, 4'hF invalid.
- frame_valid  out  1  one-cycle pulse when value updates.
- seg_error  out  1  high while the last published frame holds any invalid code.
- link_lost  out  1  high after FRAME_TIMEOUT cycles with no frame_valid.

Behaviour:
- Input stage:
  - DIGIT and DISPLAY are registered once (1-cycle sample stage).
  - All further logic uses the registered sample.
- Settle counter:
  - 8-bit stable_cnt resets to 0 whenever the sample differs from the previous sample.
  - Otherwise it increments, saturating at STABLE_CYCLES.
- Dwell FSM, two states:
  - SETTLING -> HELD on the cycle stable_cnt reaches STABLE_CYCLES-1 with the sample unchanged. On that edge the capture occurs.
  - HELD -> SETTLING on any sample change.
  - Exactly one capture per dwell.
- Capture:
  - Only when the sampled DIGIT is one-hot-low.
  - 4'b1111 and multi-low patterns are ignored: no capture, FSM still tracks.
  - The decoded code is written to shadow[i] and seen[i] is set.
- Decode map (DISPLAY -> code):
  - 03->0, 9F->1, 25->2, 0D->3, 99->4, 49->5, 41->6, 1F->7, 01->8, 09->9, FF->C.
  - Any other pattern -> F.
- Re-capture: re-capturing an already-seen digit overwrites its shadow entry; no frame is produced.
- Frame publish:
  - The cycle after seen becomes 4'b1111, value <= shadow and frame_valid = 1 for one cycle.
  - seg_error <= (any shadow code == F).
  - seen <= 0.
  - Latency: last digit stable STABLE_CYCLES samples -> frame_valid 2 cycles later, including the sample stage.
- Timeout:
  - 23-bit counter increments each cycle and clears on frame_valid.
  - At FRAME_TIMEOUT-1, link_lost <= 1 and the counter holds.
  - link_lost clears on the next frame_valid.
  - If frame publish and timeout fall on the same cycle, frame wins: link_lost stays 0 and the counter clears.
- Reset values:
  - value = 16'h0000; frame_valid = 0; seg_error = 0; link_lost = 0.
  - seen = 0, shadow = 0, stable_cnt = 0, FSM = SETTLING, timeout counter = 0.
  - Reset mid-frame discards partial captures.
- Wrap: a new frame simply replaces value; no holding or backpressure.

Optional Feature:
- Macro SSD_SCAN_DP_DECODE_EN.
- Defined:
  - DISPLAY[0] (dp) is stripped before decode; the 7-bit pattern is matched with dp forced off.
  - Extra output dp_flags[3:0] (per digit, 1 = dp lit) is published with value and reset to 0.
- Undefined:
  - dp is part of the pattern, so any lit dp decodes as F.
  - Port dp_flags is absent.

Decomposition:
- Shared package ssd_pkg holds:
  - segment pattern constants SEG_0..SEG_9 and SEG_BLANK;
  - code constants CODE_BLANK = 4'hC and CODE_INVALID = 4'hF;
  - DIGIT select constants DIG_SEL0..DIG_SEL3.
- The stopwatch encoder uses the same constants.
- One sub-module, ssd_seg_to_bcd: a combinational 8-bit pattern -> 4-bit code decoder, reusable by the encoder's self-check.

Test Plan (STABLE_CYCLES=4, FRAME_TIMEOUT=256):
- Scan 1110/03, 1101/9F, 1011/25, 0111/0D, 20 cycles each -> one frame_valid, value = 16'h3210, seg_error = 0.
- Single-cycle glitch 1110/49 between dwells, plus 3-cycle dwells -> no capture from the glitch or short dwells; value unchanged, no frame_valid.
- Digit1 shows 8'hAA in an otherwise valid scan of 5,9,0,1 -> value = 16'h59F1 (digit1 = F), seg_error = 1; next clean frame clears seg_error.
- Stop scanning (DIGIT = 1111) for 300 cycles -> link_lost = 1 at cycle 256; resume a valid scan -> link_lost = 0 on the frame_valid cycle.
- Assert reset after 3 digits captured, then scan all 4 -> exactly one frame; value equals the post-reset scan; all outputs 0 during reset.
- With SSD_SCAN_DP_DECODE_EN, digit2 = 8'h00 (8 with dp) -> value nibble 8, dp_flags = 4'b0100; without the macro the same input gives F and seg_error = 1.
